// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: DEPTH-entry circular buffer of {pc, inst} pairs between
// fetch and decode, presenting an all-zero bubble to ID whenever it is empty.
module if_id_queue #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         if_valid,
  input  logic [ADDR_W-1:0]            if_pc,
  input  logic [INST_W-1:0]            if_inst,
  output logic                         if_ready,
  input  logic                         id_stall,
  output logic                         id_valid,
  output logic [ADDR_W-1:0]            id_pc,
  output logic [INST_W-1:0]            id_inst,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = ADDR_W + INST_W;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("if_id_queue: DEPTH must be a power of two >= 2");
  end

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [ENT_W-1:0] head;

  // Handshakes depend only on registered occupancy, so id_stall never reaches if_ready.
  assign if_ready = (count_q != CNT_W'(DEPTH));
  assign id_valid = (count_q != '0);
  assign push     = if_valid && if_ready;
  assign pop      = id_valid && !id_stall;

  assign head    = mem_q[rd_ptr_q];
  assign id_pc   = id_valid ? head[ENT_W-1:INST_W] : '0;
  assign id_inst = id_valid ? head[INST_W-1:0]     : '0;
  assign count   = count_q;

  // Next-state: flush overrides any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; stale contents are masked by id_valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= {if_pc, if_inst};
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed stimulus with a scoreboard queue of expected head
// entries, checked by an independent negedge monitor.
module tb_if_id_queue;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_ready;
  logic              id_stall;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic [2:0]        count;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  if_id_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .id_stall(id_stall), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against the scoreboard, then advance the model for the coming edge.
  always @(negedge clk) begin
    int sz;
    logic [63:0] hd;
    if (!rst) begin
      exp_q.delete();
      chk("rst_ready", 64'(if_ready), 64'd1);
      chk("rst_valid", 64'(id_valid), 64'd0);
      chk("rst_pc",    64'(id_pc),    64'd0);
      chk("rst_inst",  64'(id_inst),  64'd0);
      chk("rst_count", 64'(count),    64'd0);
    end else begin
      sz = exp_q.size();
      hd = (sz != 0) ? exp_q[0] : 64'd0;
      chk("mon_count", 64'(count),    64'(sz));
      chk("mon_ready", 64'(if_ready), 64'(sz != DEPTH));
      chk("mon_valid", 64'(id_valid), 64'(sz != 0));
      chk("mon_pc",    64'(id_pc),    64'(hd[63:32]));
      chk("mon_inst",  64'(id_inst),  64'(hd[31:0]));
      if (flush) begin
        exp_q.delete();
      end else begin
        if (sz != 0 && !id_stall) void'(exp_q.pop_front());
        if (if_valid && sz != DEPTH) exp_q.push_back({if_pc, if_inst});
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                     input logic st, input logic fl);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    id_stall = st;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; id_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Streaming: one push and one pop per cycle, crossing several pointer wraps.
    for (int i = 0; i < 20; i++) cyc(1'b1, 32'(4 * i), 32'h13 + 32'(i), 1'b0, 1'b0);
    chk("stream_count", 64'(count), 64'd1);
    chk("stream_pc",    64'(id_pc), 64'h4c);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    chk("stream_drain", 64'(count), 64'd0);

    // Fill under stall, then release with the fifth offer held by IF.
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(4 * i), 32'hA0 + 32'(i), 1'b1, 1'b0);
    chk("fill_count", 64'(count),    64'd4);
    chk("fill_ready", 64'(if_ready), 64'd0);
    cyc(1'b1, 32'h10, 32'hA4, 1'b1, 1'b0);
    chk("held_count", 64'(count),    64'd4);
    chk("held_pc",    64'(id_pc),    64'h0);
    cyc(1'b1, 32'h10, 32'hA4, 1'b0, 1'b0);
    chk("fullpop_count", 64'(count), 64'd3);
    chk("fullpop_pc",    64'(id_pc), 64'h4);
    cyc(1'b1, 32'h10, 32'hA4, 1'b0, 1'b0);
    chk("accept_count", 64'(count),  64'd3);
    chk("accept_pc",    64'(id_pc),  64'h8);
    repeat (4) cyc(1'b0, '0, '0, 1'b0, 1'b0);
    chk("fill_drain", 64'(count), 64'd0);

    // Flush with simultaneous push and pop.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h40 + 32'(4 * i), 32'hB0 + 32'(i), 1'b1, 1'b0);
    chk("preflush_count", 64'(count), 64'd3);
    cyc(1'b1, 32'h200, 32'hCAFE, 1'b0, 1'b1);
    chk("flush_count", 64'(count),    64'd0);
    chk("flush_valid", 64'(id_valid), 64'd0);
    chk("flush_pc",    64'(id_pc),    64'd0);
    chk("flush_inst",  64'(id_inst),  64'd0);
    chk("flush_ready", 64'(if_ready), 64'd1);
    cyc(1'b1, 32'h100, 32'hDEAD, 1'b1, 1'b0);
    chk("postflush_pc",    64'(id_pc),   64'h100);
    chk("postflush_inst",  64'(id_inst), 64'hDEAD);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);

    // Asynchronous reset mid-stream, checked before any clock edge.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h80 + 32'(4 * i), 32'hC0 + 32'(i), 1'b1, 1'b0);
    chk("prereset_count", 64'(count), 64'd3);
    if_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_count", 64'(count),    64'd0);
    chk("async_valid", 64'(id_valid), 64'd0);
    chk("async_pc",    64'(id_pc),    64'd0);
    chk("async_inst",  64'(id_inst),  64'd0);
    chk("async_ready", 64'(if_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Bubble: empty queue with ID ready never underflows.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b0);
      chk("bubble_count", 64'(count),    64'd0);
      chk("bubble_valid", 64'(id_valid), 64'd0);
      chk("bubble_pc",    64'(id_pc),    64'd0);
    end

    repeat (2) cyc(1'b0, '0, '0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
